logic_op_arbiter: RTL and testbench
===================================

# logic_op_arbiter

Shares one N-bit bitwise logic unit between two requesters. Each requester presents an opcode and two operands over a valid/ready handshake. A round-robin arbiter grants one request per cycle, and the winning result is held in a single output register with its own valid/ready handshake, tagged with the requester ID. The block sits between the requesting control blocks and the parameterized logic datapath, so that datapath is never instantiated twice.

## Interface
- N, default 4: operand and result width in bits, minimum 1.
- CNT_W, default 16: width of the grant counters (only when LOGIC_ARB_STATS_EN is defined).
- clk  input  1  sole clock; rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid, req1_valid  input  1 each  request present.
- req0_ready, req1_ready  output  1 each  request accepted this cycle (grant).
- req0_op, req1_op  input  2 each  opcode: 00 AND, 01 OR, 10 XOR, 11 XNOR.
- req0_a, req0_b, req1_a, req1_b  input  N each  operands.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_data  output  N  result.
- out_id  output  1  requester that produced out_data (0 or 1).
- gnt_cnt0, gnt_cnt1  output  CNT_W each  accepted-request counts (only when LOGIC_ARB_STATS_EN is defined).

## Operation
- The output register has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = !out_valid || out_ready. The register may load in any cycle it is empty or being drained.
- Arbitration (combinational):
  - Only one requester valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - last_gnt is updated only on an accepted transfer.
- reqX_ready = can_accept && (X is the winner). The loser's ready is 0. A ready is never asserted without the matching valid.
- On a transfer (valid && ready):
  - out_data <= op(a,b) of the winner.
  - out_id <= winner.
  - out_valid <= 1.
- If out_valid && out_ready and there is no transfer: out_valid <= 0. out_data and out_id keep their values.
- Opcode results:
  - AND = a&b, OR = a|b, XOR = a^b, XNOR = ~(a^b).
  - All results are exactly N bits; no carries, no sign handling.
- Requesters must hold op, a and b stable while valid is high and ready is low. The arbiter never drops a request once it is presented.

## Timing
- Reset values: out_valid=0, out_data=0, out_id=0, last_gnt=1 (requester 0 wins the first contention), counters=0. reqX_ready=0 while rst_n is low.
- Latency: the result appears on out_data/out_valid one cycle after the accepting edge.
- Throughput: one result per cycle when out_ready is held high. Back-to-back loads into a draining register are allowed.
- FULL with out_ready=0: both readies are 0; the register and out_data are held unchanged.
- Simultaneous drain and load: the new result replaces the old one in the same edge; out_valid stays 1.
- Reset asserted mid-transfer: the register empties immediately (asynchronous). The pending result is lost; requesters re-present after reset.

## Configuration
- LOGIC_ARB_STATS_EN defined:
  - Adds ports gnt_cnt0 and gnt_cnt1.
  - Each counter increments by 1 on every accepted transfer from its requester.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - Counters clear only on reset.
- LOGIC_ARB_STATS_EN undefined: the counters and their ports do not exist. All other behaviour is identical.

## Structure
- Shared package logic_arb_pkg:
  - opcode localparams OP_AND, OP_OR, OP_XOR, OP_XNOR (2 bits);
  - state encoding ST_EMPTY / ST_FULL;
  - requester ID width (1).
- Sub-module logic_op_unit, combinational: N-bit op/a/b in, result out. It is instantiated once and fed by the arbiter's winner mux.

## Test plan
- Reset → all outputs 0. Then req0 alone: op=01, a=4'b1010, b=4'b0101, out_ready=1 → next cycle out_valid=1, out_data=4'b1111, out_id=0.
- Both valid every cycle, out_ready=1 → grants alternate 0,1,0,1 starting with req0. XOR of a=4'b1100, b=4'b1010 yields 4'b0110.
- FULL with out_ready=0 for 5 cycles → req0_ready=req1_ready=0; out_data and out_id are unchanged; no request is lost after out_ready returns.
- Simultaneous drain and load: out_ready=1 with req1 valid, op=11, a=b=4'b0011 → out_valid stays 1 and out_data=4'b1111 with out_id=1 in the next cycle.
- rst_n pulled low while FULL → out_valid=0 immediately, without waiting for clk.
- With LOGIC_ARB_STATS_EN and CNT_W=2: accept 5 req0 transfers → gnt_cnt0=3 (saturated), gnt_cnt1=0.

Source files
------------

// File: rtl/logic_arb_pkg.sv
// rtl/logic_arb_pkg.sv - shared opcodes, state encoding and ID width for logic_op_arbiter
package logic_arb_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    localparam int ID_W = 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/logic_op_unit.sv
// rtl/logic_op_unit.sv - combinational N-bit bitwise logic unit (AND/OR/XOR/XNOR)
module logic_op_unit
    import logic_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [1:0]   i_op,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_res
);

    always_comb begin
        o_res = '0;
        case (i_op)
            OP_AND:  o_res = i_a & i_b;
            OP_OR:   o_res = i_a | i_b;
            OP_XOR:  o_res = i_a ^ i_b;
            default: o_res = ~(i_a ^ i_b);
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// rtl/logic_op_arbiter.sv - round-robin share of one logic unit; LOGIC_ARB_STATS_EN adds grant counters
module logic_op_arbiter
    import logic_arb_pkg::*;
#(
    parameter int N = 4
`ifdef LOGIC_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [1:0]      req0_op,
    input  logic [N-1:0]    req0_a,
    input  logic [N-1:0]    req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [1:0]      req1_op,
    input  logic [N-1:0]    req1_a,
    input  logic [N-1:0]    req1_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
    output logic [ID_W-1:0] out_id
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
`endif
);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic            r_last_gnt;
    logic [N-1:0]    r_data;
    logic [ID_W-1:0] r_id;

    logic            w_winner;
    logic            w_can_accept;
    logic            w_xfer;
    logic [1:0]      w_op;
    logic [N-1:0]    w_a;
    logic [N-1:0]    w_b;
    logic [N-1:0]    w_res;

    // On contention the requester not granted last wins; a lone requester always wins.
    always_comb begin
        w_winner = 1'b0;
        if (req0_valid && req1_valid) begin
            w_winner = ~r_last_gnt;
        end else if (req1_valid) begin
            w_winner = 1'b1;
        end
    end

    // Readies are gated by rst_n so nothing is granted while the block is held in reset.
    assign w_can_accept = (r_state == ST_EMPTY) || out_ready;
    assign req0_ready   = rst_n && w_can_accept && req0_valid && !w_winner;
    assign req1_ready   = rst_n && w_can_accept && req1_valid &&  w_winner;
    assign w_xfer       = req0_ready || req1_ready;

    assign w_op = w_winner ? req1_op : req0_op;
    assign w_a  = w_winner ? req1_a  : req0_a;
    assign w_b  = w_winner ? req1_b  : req0_b;

    logic_op_unit #(.N(N)) u_op_unit (
        .i_op  (w_op),
        .i_a   (w_a),
        .i_b   (w_b),
        .o_res (w_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_xfer) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && out_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Data and ID only move on a transfer; a plain drain leaves them as they were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_id       <= '0;
            r_last_gnt <= 1'b1;
        end else if (w_xfer) begin
            r_data     <= w_res;
            r_id       <= ID_W'(w_winner);
            r_last_gnt <= w_winner;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_id    = r_id;

`ifdef LOGIC_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (req0_ready && (r_cnt0 != {CNT_W{1'b1}})) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (req1_ready && (r_cnt1 != {CNT_W{1'b1}})) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign gnt_cnt0 = r_cnt0;
    assign gnt_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb/tb_logic_op_arbiter.sv - directed table-driven bench for logic_op_arbiter
module tb_logic_op_arbiter;

    localparam int N = 4;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic       out_valid;
    logic       out_ready;
    logic [N-1:0] out_data;
    logic [0:0] out_id;
`ifdef LOGIC_ARB_STATS_EN
    logic [1:0] gnt_cnt0, gnt_cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    logic_op_arbiter #(
        .N(N)
`ifdef LOGIC_ARB_STATS_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id)
`ifdef LOGIC_ARB_STATS_EN
        , .gnt_cnt0 (gnt_cnt0)
        , .gnt_cnt1 (gnt_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic [1:0] op0;
        logic [3:0] a0;
        logic [3:0] b0;
        logic       v1;
        logic [1:0] op1;
        logic [3:0] a1;
        logic [3:0] b1;
        logic       ordy;
        logic       e_r0;
        logic       e_r1;
        logic       e_ov;
        logic [3:0] e_d;
        logic       e_id;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic v0, logic [1:0] op0, logic [3:0] a0, logic [3:0] b0,
                                logic v1, logic [1:0] op1, logic [3:0] a1, logic [3:0] b1,
                                logic ordy, logic e_r0, logic e_r1, logic e_ov,
                                logic [3:0] e_d, logic e_id);
        vec_t v;
        v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
        v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1;
        v.ordy = ordy; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_ov = e_ov;
        v.e_d = e_d; v.e_id = e_id;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
        out_ready  = v.ordy;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        req0_op = 2'b00; req0_a = '0; req0_b = '0;
        req1_op = 2'b00; req1_a = '0; req1_b = '0;
    endtask

    initial begin
        // Sequential table: each row drives one cycle; expected readies are
        // seen before the edge, expected register contents just after it.
        vecs[0]  = mk(1, 2'b01, 4'b1010, 4'b0101, 0, 2'b00, 4'b0000, 4'b0000, 1, 1, 0, 1, 4'b1111, 0);
        vecs[1]  = mk(1, 2'b10, 4'b1100, 4'b1010, 1, 2'b00, 4'b1100, 4'b1010, 1, 0, 1, 1, 4'b1000, 1);
        vecs[2]  = mk(1, 2'b10, 4'b1100, 4'b1010, 1, 2'b00, 4'b1100, 4'b1010, 1, 1, 0, 1, 4'b0110, 0);
        vecs[3]  = mk(1, 2'b10, 4'b1100, 4'b1010, 1, 2'b00, 4'b1100, 4'b1010, 1, 0, 1, 1, 4'b1000, 1);
        vecs[4]  = mk(1, 2'b10, 4'b1100, 4'b1010, 1, 2'b11, 4'b0011, 4'b0011, 0, 0, 0, 1, 4'b1000, 1);
        vecs[5]  = mk(1, 2'b10, 4'b1100, 4'b1010, 1, 2'b11, 4'b0011, 4'b0011, 0, 0, 0, 1, 4'b1000, 1);
        vecs[6]  = mk(1, 2'b10, 4'b1100, 4'b1010, 1, 2'b11, 4'b0011, 4'b0011, 0, 0, 0, 1, 4'b1000, 1);
        vecs[7]  = mk(1, 2'b10, 4'b1100, 4'b1010, 1, 2'b11, 4'b0011, 4'b0011, 0, 0, 0, 1, 4'b1000, 1);
        vecs[8]  = mk(1, 2'b10, 4'b1100, 4'b1010, 1, 2'b11, 4'b0011, 4'b0011, 0, 0, 0, 1, 4'b1000, 1);
        vecs[9]  = mk(1, 2'b10, 4'b1100, 4'b1010, 1, 2'b11, 4'b0011, 4'b0011, 1, 1, 0, 1, 4'b0110, 0);
        vecs[10] = mk(0, 2'b00, 4'b0000, 4'b0000, 1, 2'b11, 4'b0011, 4'b0011, 1, 0, 1, 1, 4'b1111, 1);
        vecs[11] = mk(0, 2'b00, 4'b0000, 4'b0000, 0, 2'b00, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b1111, 1);
        vecs[12] = mk(0, 2'b00, 4'b0000, 4'b0000, 0, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b1111, 1);
        vecs[13] = mk(1, 2'b00, 4'b1111, 4'b0101, 0, 2'b00, 4'b0000, 4'b0000, 0, 1, 0, 1, 4'b0101, 0);
        vecs[14] = mk(0, 2'b00, 4'b0000, 4'b0000, 1, 2'b01, 4'b0001, 4'b0010, 0, 0, 0, 1, 4'b0101, 0);
        vecs[15] = mk(0, 2'b00, 4'b0000, 4'b0000, 1, 2'b01, 4'b0001, 4'b0010, 1, 0, 1, 1, 4'b0011, 1);
        vecs[16] = mk(1, 2'b10, 4'b1111, 4'b1111, 1, 2'b11, 4'b0000, 4'b1111, 1, 1, 0, 1, 4'b0000, 0);
        vecs[17] = mk(0, 2'b00, 4'b0000, 4'b0000, 1, 2'b11, 4'b0000, 4'b1111, 1, 0, 1, 1, 4'b0000, 1);

        idle();
        rst_n = 1'b0;
        #1;
        chk("reset_rdy0", {31'b0, req0_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_data",  {28'b0, out_data},  32'd0);
        chk("reset_id",    {31'b0, out_id},    32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_rdy0", i), {31'b0, req0_ready}, {31'b0, vecs[i].e_r0});
            chk($sformatf("v%0d_rdy1", i), {31'b0, req1_ready}, {31'b0, vecs[i].e_r1});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
            chk($sformatf("v%0d_data", i),  {28'b0, out_data},  {28'b0, vecs[i].e_d});
            chk($sformatf("v%0d_id", i),    {31'b0, out_id},    {31'b0, vecs[i].e_id});
        end

        // Asynchronous reset mid-cycle while FULL empties the register without a clock edge.
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 4'b1000; req0_b = 4'b0001;
        req1_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_data",  {28'b0, out_data},  32'd0);
        chk("async_rst_rdy0",  {31'b0, req0_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_valid", {31'b0, out_valid}, 32'd0);
        rst_n = 1'b1;
        idle();
        @(posedge clk);
        #1;

        // First contention after reset goes to requester 0, then alternates.
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 4'b1100; req0_b = 4'b1010;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 4'b1100; req1_b = 4'b1010;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("alt%0d_rdy0", k), {31'b0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("alt%0d_rdy1", k), {31'b0, req1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("alt%0d_data", k), {28'b0, out_data}, (k % 2 == 0) ? 32'h6 : 32'h8);
            chk($sformatf("alt%0d_id", k),   {31'b0, out_id},   (k % 2 == 0) ? 32'd0 : 32'd1);
        end

`ifdef LOGIC_ARB_STATS_EN
        idle();
        rst_n = 1'b0;
        #1;
        chk("cnt0_reset", {30'b0, gnt_cnt0}, 32'd0);
        chk("cnt1_reset", {30'b0, gnt_cnt1}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 4'b1111; req0_b = 4'b1111;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("cnt0_sat", {30'b0, gnt_cnt0}, 32'd3);
        chk("cnt1_zero", {30'b0, gnt_cnt1}, 32'd0);
`endif

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
